// File: rtl/dr_l2req_tracker_if.sv
// Channel bundle for dr_l2req_tracker: L2 request, memory fill/ack, L2 snack and status.
// slave is the tracker side, master is the environment side.
interface dr_l2req_tracker_if #(
    parameter int NENTRIES = 4,
    parameter int PADDR_W  = 50,
    parameter int L2TID_W  = 6,
    parameter int DATA_W   = 512
);
    localparam int TAG_W = $clog2(NENTRIES);

    logic               l2todr_req_valid;
    logic               l2todr_req_retry;
    logic [5:0]         l2todr_req_l2id;
    logic [L2TID_W-1:0] l2todr_req_l2tid;
    logic [PADDR_W-1:0] l2todr_req_paddr;
    logic               drtomem_req_valid;
    logic               drtomem_req_retry;
    logic [TAG_W-1:0]   drtomem_req_tag;
    logic [PADDR_W-1:0] drtomem_req_paddr;
    logic               memtodr_ack_valid;
    logic               memtodr_ack_retry;
    logic [TAG_W-1:0]   memtodr_ack_tag;
    logic [DATA_W-1:0]  memtodr_ack_data;
    logic               drtol2_snack_valid;
    logic               drtol2_snack_retry;
    logic [5:0]         drtol2_snack_l2id;
    logic [L2TID_W-1:0] drtol2_snack_l2tid;
    logic [PADDR_W-1:0] drtol2_snack_paddr;
    logic [DATA_W-1:0]  drtol2_snack_data;
    logic [TAG_W:0]     busy_cnt;
    logic               err_tag;

    modport slave (
        input  l2todr_req_valid, l2todr_req_l2id, l2todr_req_l2tid, l2todr_req_paddr,
        output l2todr_req_retry,
        output drtomem_req_valid, drtomem_req_tag, drtomem_req_paddr,
        input  drtomem_req_retry,
        input  memtodr_ack_valid, memtodr_ack_tag, memtodr_ack_data,
        output memtodr_ack_retry,
        output drtol2_snack_valid, drtol2_snack_l2id, drtol2_snack_l2tid,
        output drtol2_snack_paddr, drtol2_snack_data,
        input  drtol2_snack_retry,
        output busy_cnt, err_tag
    );

    modport master (
        output l2todr_req_valid, l2todr_req_l2id, l2todr_req_l2tid, l2todr_req_paddr,
        input  l2todr_req_retry,
        input  drtomem_req_valid, drtomem_req_tag, drtomem_req_paddr,
        output drtomem_req_retry,
        output memtodr_ack_valid, memtodr_ack_tag, memtodr_ack_data,
        input  memtodr_ack_retry,
        input  drtol2_snack_valid, drtol2_snack_l2id, drtol2_snack_l2tid,
        input  drtol2_snack_paddr, drtol2_snack_data,
        output drtol2_snack_retry,
        input  busy_cnt, err_tag
    );
endinterface

// File: rtl/dr_l2req_tracker.sv
// Directory-side L2 request tracker: one entry per L2 request, memory fill, snack back to the L2.
// Define DR_L2REQ_ADDR_CONFLICT_EN to retry requests whose line is already outstanding.
module dr_l2req_tracker #(
    parameter int NENTRIES = 4,
    parameter int PADDR_W  = 50,
    parameter int L2TID_W  = 6,
    parameter int DATA_W   = 512
) (
    input  logic              clk,
    input  logic              reset,
    dr_l2req_tracker_if.slave bus
);
    localparam int TAG_W = $clog2(NENTRIES);

    typedef enum logic [1:0] {S_FREE, S_ISSUE, S_WAIT, S_RESP} ent_state_e;

    ent_state_e          state_q [NENTRIES];
    ent_state_e          state_d [NENTRIES];
    logic [5:0]          l2id_q  [NENTRIES];
    logic [L2TID_W-1:0]  l2tid_q [NENTRIES];
    logic [PADDR_W-1:0]  paddr_q [NENTRIES];
    logic [DATA_W-1:0]   data_q  [NENTRIES];

    logic                mem_vld_q, mem_vld_d;
    logic [TAG_W-1:0]    mem_tag_q, mem_tag_d;
    logic [PADDR_W-1:0]  mem_paddr_q, mem_paddr_d;
    logic                snk_vld_q, snk_vld_d;
    logic [5:0]          snk_l2id_q, snk_l2id_d;
    logic [L2TID_W-1:0]  snk_l2tid_q, snk_l2tid_d;
    logic [PADDR_W-1:0]  snk_paddr_q, snk_paddr_d;
    logic [DATA_W-1:0]   snk_data_q, snk_data_d;
    logic [TAG_W:0]      busy_q, busy_d;
    logic                err_q, err_d;

    logic                any_free, conflict, req_retry, accept, ack_ok;
    logic [TAG_W-1:0]    alloc_idx;
    logic [NENTRIES-1:0] issue_vec, resp_vec;
    logic                mem_load, mem_pick, snk_load, snk_pick;
    logic [TAG_W-1:0]    mem_sel, snk_sel;

    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        conflict  = 1'b0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE) begin
                any_free  = 1'b1;
                alloc_idx = TAG_W'(i);
            end
        end
`ifdef DR_L2REQ_ADDR_CONFLICT_EN
        for (int i = 0; i < NENTRIES; i++) begin
            if (state_q[i] != S_FREE && paddr_q[i] == bus.l2todr_req_paddr) conflict = 1'b1;
        end
`endif
        req_retry = !any_free || (bus.l2todr_req_valid && conflict);
        accept    = bus.l2todr_req_valid && !req_retry;
        ack_ok    = bus.memtodr_ack_valid && (state_q[bus.memtodr_ack_tag] == S_WAIT);

        // The entry accepted (or acked) this cycle competes directly, giving one cycle per hop.
        issue_vec = '0;
        resp_vec  = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            issue_vec[i] = (state_q[i] == S_ISSUE) || (accept && alloc_idx == TAG_W'(i));
            resp_vec[i]  = (state_q[i] == S_RESP) || (ack_ok && bus.memtodr_ack_tag == TAG_W'(i));
        end
        mem_pick = |issue_vec;
        snk_pick = |resp_vec;
        mem_sel  = '0;
        snk_sel  = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (issue_vec[i]) mem_sel = TAG_W'(i);
            if (resp_vec[i])  snk_sel = TAG_W'(i);
        end
        mem_load = !mem_vld_q || !bus.drtomem_req_retry;
        snk_load = !snk_vld_q || !bus.drtol2_snack_retry;
    end

    always_comb begin
        for (int i = 0; i < NENTRIES; i++) state_d[i] = state_q[i];
        if (accept)               state_d[alloc_idx] = S_ISSUE;
        if (mem_load && mem_pick) state_d[mem_sel] = S_WAIT;
        if (ack_ok)               state_d[bus.memtodr_ack_tag] = S_RESP;
        if (snk_load && snk_pick) state_d[snk_sel] = S_FREE;

        mem_vld_d   = mem_vld_q;
        mem_tag_d   = mem_tag_q;
        mem_paddr_d = mem_paddr_q;
        if (mem_load) begin
            mem_vld_d = mem_pick;
            if (mem_pick) begin
                mem_tag_d   = mem_sel;
                mem_paddr_d = (accept && mem_sel == alloc_idx) ? bus.l2todr_req_paddr
                                                               : paddr_q[mem_sel];
            end
        end

        snk_vld_d   = snk_vld_q;
        snk_l2id_d  = snk_l2id_q;
        snk_l2tid_d = snk_l2tid_q;
        snk_paddr_d = snk_paddr_q;
        snk_data_d  = snk_data_q;
        if (snk_load) begin
            snk_vld_d = snk_pick;
            if (snk_pick) begin
                snk_l2id_d  = l2id_q[snk_sel];
                snk_l2tid_d = l2tid_q[snk_sel];
                snk_paddr_d = paddr_q[snk_sel];
                snk_data_d  = (ack_ok && snk_sel == bus.memtodr_ack_tag) ? bus.memtodr_ack_data
                                                                         : data_q[snk_sel];
            end
        end

        // Count of the registered entry states, so busy_cnt trails state by one cycle.
        busy_d = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (state_q[i] != S_FREE) busy_d = busy_d + (TAG_W + 1)'(1);
        end
        err_d = err_q || (bus.memtodr_ack_valid && !ack_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NENTRIES; i++) state_q[i] <= S_FREE;
            mem_vld_q   <= 1'b0;
            mem_tag_q   <= '0;
            mem_paddr_q <= '0;
            snk_vld_q   <= 1'b0;
            snk_l2id_q  <= '0;
            snk_l2tid_q <= '0;
            snk_paddr_q <= '0;
            snk_data_q  <= '0;
            busy_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NENTRIES; i++) state_q[i] <= state_d[i];
            mem_vld_q   <= mem_vld_d;
            mem_tag_q   <= mem_tag_d;
            mem_paddr_q <= mem_paddr_d;
            snk_vld_q   <= snk_vld_d;
            snk_l2id_q  <= snk_l2id_d;
            snk_l2tid_q <= snk_l2tid_d;
            snk_paddr_q <= snk_paddr_d;
            snk_data_q  <= snk_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            l2id_q[alloc_idx]  <= bus.l2todr_req_l2id;
            l2tid_q[alloc_idx] <= bus.l2todr_req_l2tid;
            paddr_q[alloc_idx] <= bus.l2todr_req_paddr;
        end
        if (ack_ok) data_q[bus.memtodr_ack_tag] <= bus.memtodr_ack_data;
    end

    assign bus.l2todr_req_retry   = req_retry;
    assign bus.drtomem_req_valid  = mem_vld_q;
    assign bus.drtomem_req_tag    = mem_tag_q;
    assign bus.drtomem_req_paddr  = mem_paddr_q;
    assign bus.memtodr_ack_retry  = 1'b0;
    assign bus.drtol2_snack_valid = snk_vld_q;
    assign bus.drtol2_snack_l2id  = snk_l2id_q;
    assign bus.drtol2_snack_l2tid = snk_l2tid_q;
    assign bus.drtol2_snack_paddr = snk_paddr_q;
    assign bus.drtol2_snack_data  = snk_data_q;
    assign bus.busy_cnt           = busy_q;
    assign bus.err_tag            = err_q;
endmodule

// File: doc/dr_l2req_tracker.md
Name: dr_l2req_tracker

Overview:
Directory-side responder for the L2-to-directory request channel. It accepts aggregated L2 requests, allocates a tracker entry per request, and issues line fills to memory. On the memory ack it returns a snack to the originating L2, tagged with l2id/l2tid, so the L2-side aggregator can route it by l2id.

Parameters:
NENTRIES, 4, outstanding tracker entries (power of 2, >=2)
PADDR_W, 50, physical address width
L2TID_W, 6, L2 transaction id width
DATA_W, 512, line data width
TAG_W, $clog2(NENTRIES), memory tag width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
l2todr_req_valid  in  1  L2 request valid
l2todr_req_retry  out  1  request back-pressure
l2todr_req_l2id  in  6  requesting L2 id
l2todr_req_l2tid  in  L2TID_W  L2 transaction id
l2todr_req_paddr  in  PADDR_W  line address
drtomem_req_valid  out  1  memory fill request valid
drtomem_req_retry  in  1  memory back-pressure
drtomem_req_tag  out  TAG_W  tracker index
drtomem_req_paddr  out  PADDR_W  fill address
memtodr_ack_valid  in  1  fill data valid
memtodr_ack_retry  out  1  tied 0
memtodr_ack_tag  in  TAG_W  tracker index
memtodr_ack_data  in  DATA_W  line data
drtol2_snack_valid  out  1  response valid
drtol2_snack_retry  in  1  L2 back-pressure
drtol2_snack_l2id  out  6  destination L2
drtol2_snack_l2tid  out  L2TID_W  echoed transaction id
drtol2_snack_paddr  out  PADDR_W  echoed address
drtol2_snack_data  out  DATA_W  line data
busy_cnt  out  TAG_W+1  entries not FREE
err_tag  out  1  sticky: ack to an entry not in WAIT

Behaviour:
- Handshake on all channels: a transfer occurs when valid && !retry. The sender holds valid and payload stable while retry=1.
- Entry states: FREE -> ISSUE (request accepted) -> WAIT (loaded into drtomem output register) -> RESP (ack received) -> FREE (loaded into snack output register). Each entry stores l2id, l2tid, paddr, and data.
- l2todr_req_retry = 1 when no entry is FREE. It is computed from registered state only, independent of l2todr_req_valid. A free occurring in the same cycle does not lower retry until the next cycle.
- Allocation uses the lowest-index FREE entry. The entry is in ISSUE from the cycle after acceptance.
- drtomem output register: loads when empty, or when its current contents transfer this cycle. It takes the lowest-index ISSUE entry, which moves to WAIT. drtomem_req_valid first rises the cycle after request acceptance (1-cycle latency).
- memtodr_ack is always accepted. Valid with an entry in WAIT: store data, entry -> RESP next cycle. Valid with an entry not in WAIT: ignored, err_tag set, and it stays 1 until reset.
- Snack output register: same load rule as drtomem, using the lowest-index RESP entry. That entry -> FREE in the load cycle, with its payload copied. snack_valid first rises the cycle after the ack.
- Minimum round trip with no retries: request at cycle 0, drtomem_req_valid at 1, ack at k, snack valid at k+1.
- An entry may be allocated and a different entry freed in the same cycle. An ack and a snack load may target different entries in the same cycle.
- busy_cnt is the registered count of non-FREE entries and ranges 0..NENTRIES.
- Reset (synchronous, any time, including mid-transaction): all entries FREE, and both output registers cleared. Outputs after reset: drtomem_req_valid=0, drtol2_snack_valid=0, payload outputs=0, l2todr_req_retry=0, busy_cnt=0, err_tag=0. In-flight memory acks arriving after reset are treated as stale (err_tag set).

Optional Feature:
DR_L2REQ_ADDR_CONFLICT_EN:
- Defined: an incoming request whose paddr equals the paddr of any non-FREE entry is retried (l2todr_req_retry=1 while that request is presented), even if entries are free. Only one transaction per line is outstanding at a time.
- Undefined: there is no address comparison, and duplicate lines may be outstanding concurrently.

Test Plan:
- Single request: l2id=1, l2tid=5, paddr=0x1000 at cycle 0; memory never retries; ack tag=0, data=D at cycle 3. Required: drtomem valid at cycle 1 with tag=0; snack valid at cycle 4 with l2id=1, l2tid=5, paddr=0x1000, data=D; busy_cnt returns to 0 at cycle 5.
- Fill: NENTRIES=4 back-to-back requests with no acks. Required: tags 0,1,2,3 issued in order; busy_cnt=4; l2todr_req_retry=1 on the 5th request until the first snack load, then it is accepted into the freed entry.
- Out-of-order acks: acks arrive for tags 2, 0, 1. Required: snacks emitted in ack order with the matching l2tid of each.
- Back-pressure: hold drtol2_snack_retry=1 for 10 cycles. Required: snack payload stable throughout; exactly one transfer after release; drtomem_req_retry held similarly gives no duplicate tag.
- Stray ack: ack tag=3 while entry 3 is FREE. Required: err_tag=1 the next cycle and no snack; reset clears it.
- Conflict (macro defined): two requests with paddr=0x2000. Required: second retried until the first's snack loads; with the macro undefined, both are tracked.
